// File: rtl/fp_pkg.sv
// Shared floating-point types and helpers for the pipelined multiplier.
// Format-dependent constants are derived from the exponent/mantissa widths.
package fp_pkg;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    localparam logic RM_RNE = 1'b0;
    localparam logic RM_RTZ = 1'b1;

    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_NV = 3;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Returned at full 64-bit width; callers keep the low 1+exp_w+man_w bits.
    function automatic logic [63:0] fp_canon_nan(input int unsigned exp_w,
                                                 input int unsigned man_w);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Operand unpack: classify, and normalise subnormals so the mantissa always carries a
// leading one at bit MAN_W with the exponent adjusted to match.
module fp_unpack
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    localparam int unsigned W = 1 + EXP_W + MAN_W,
    localparam int unsigned EW = EXP_W + 2
) (
    input  logic [W-1:0]          x_i,
    output logic                  sign_o,
    output fp_class_e             cls_o,
    output logic signed [EW-1:0]  exp_o,
    output logic [MAN_W:0]        man_o
);

    localparam logic signed [EW-1:0] BIAS_X = EW'(fp_bias(EXP_W));

    logic [EXP_W-1:0] e_fld;
    logic [MAN_W-1:0] m_fld;
    int               lz;
    logic             found;

    assign sign_o = x_i[W-1];
    assign e_fld  = x_i[W-2 -: EXP_W];
    assign m_fld  = x_i[MAN_W-1:0];

    always_comb begin
        lz    = 0;
        found = 1'b0;
        for (int i = int'(MAN_W) - 1; i >= 0; i--) begin
            if (!found && m_fld[i]) begin
                lz    = int'(MAN_W) - 1 - i;
                found = 1'b1;
            end
        end

        cls_o = NORM;
        exp_o = $signed({2'b00, e_fld}) - BIAS_X;
        man_o = {1'b1, m_fld};

        if (e_fld == '1) begin
            exp_o = '0;
            man_o = '0;
            if (m_fld == '0) begin
                cls_o = INF;
            end else if (m_fld[MAN_W-1]) begin
                cls_o = QNAN;
            end else begin
                cls_o = SNAN;
            end
        end else if (e_fld == '0) begin
            if (m_fld == '0) begin
                cls_o = ZERO;
                exp_o = '0;
                man_o = '0;
            end else begin
                // Value is 0.m * 2^(1-bias); shifting lz+1 puts the leading one on top.
                cls_o = SUB;
                exp_o = -BIAS_X - EW'(lz);
                man_o = {1'b0, m_fld} << (lz + 1);
            end
        end
    end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage IEEE-754 multiplier (unpack / multiply / round+pack) with a global stall
// driven by the output handshake; RNE or RTZ per transaction, non-sticky flags.
module fmul_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    localparam int unsigned W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         rm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic [3:0]   flags
);

    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam logic [63:0] NAN_FULL = fp_canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0] NAN_W = NAN_FULL[W-1:0];
    localparam logic signed [EW-1:0] BIAS_X = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] BIAS_X1 = EW'(fp_bias(EXP_W) + 32'd1);
    localparam logic [EW-1:0] EXP_MAX = EW'((32'd1 << EXP_W) - 32'd1);

    typedef struct packed {
        logic           valid;
        logic           rm;
        logic           sign;
        logic           spec;
        logic           nv;
        logic [W-1:0]   res;
        logic [EW-1:0]  exp;
        logic [MAN_W:0] man_a;
        logic [MAN_W:0] man_b;
    } s1_t;

    typedef struct packed {
        logic          valid;
        logic          rm;
        logic          sign;
        logic          spec;
        logic          nv;
        logic [W-1:0]  res;
        logic [EW-1:0] exp;
        logic [PW-1:0] prod;
    } s2_t;

    s1_t s1_in, s1_d, s1_q;
    s2_t s2_in, s2_d, s2_q;

    logic         out_valid_d, out_valid_q;
    logic [W-1:0] out_d, out_q;
    logic [3:0]   flags_d, flags_q;
    logic         advance;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance && rst_n;

    // ---------------- S1: unpack and special-case decode ----------------
    logic                 sign_a, sign_b, sign_r;
    fp_class_e            cls_a, cls_b;
    logic signed [EW-1:0] exp_a, exp_b;
    logic [MAN_W:0]       man_a, man_b;

    fp_unpack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_unpack_a (
        .x_i    (a),
        .sign_o (sign_a),
        .cls_o  (cls_a),
        .exp_o  (exp_a),
        .man_o  (man_a)
    );

    fp_unpack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_unpack_b (
        .x_i    (b),
        .sign_o (sign_b),
        .cls_o  (cls_b),
        .exp_o  (exp_b),
        .man_o  (man_b)
    );

    assign sign_r = sign_a ^ sign_b;

    always_comb begin
        s1_in       = '0;
        s1_in.valid = in_valid;
        s1_in.rm    = rm;
        s1_in.sign  = sign_r;
        s1_in.exp   = exp_a + exp_b;
        s1_in.man_a = man_a;
        s1_in.man_b = man_b;
        s1_in.spec  = 1'b1;
        if (cls_a == SNAN || cls_b == SNAN) begin
            s1_in.res = NAN_W;
            s1_in.nv  = 1'b1;
        end else if (cls_a == QNAN || cls_b == QNAN) begin
            s1_in.res = NAN_W;
        end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
            s1_in.res = NAN_W;
            s1_in.nv  = 1'b1;
        end else if (cls_a == INF || cls_b == INF) begin
            s1_in.res = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            s1_in.res = {sign_r, {(W-1){1'b0}}};
        end else begin
            s1_in.spec = 1'b0;
        end
        s1_d = advance ? s1_in : s1_q;
    end

    // ---------------- S2: mantissa multiply ----------------
    always_comb begin
        s2_in       = '0;
        s2_in.valid = s1_q.valid;
        s2_in.rm    = s1_q.rm;
        s2_in.sign  = s1_q.sign;
        s2_in.spec  = s1_q.spec;
        s2_in.nv    = s1_q.nv;
        s2_in.res   = s1_q.res;
        s2_in.exp   = s1_q.exp;
        s2_in.prod  = s1_q.man_a * s1_q.man_b;
        s2_d        = advance ? s2_in : s2_q;
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [PW-1:0]         sig, shf;
    logic signed [EW-1:0]  be;
    logic [EW-1:0]         e_pre, be_r;
    logic [MAN_W-1:0]      frac;
    logic [EW+MAN_W-1:0]   rounded;
    logic                  tiny, sh_sticky, guard, rnd, stk, inc, inexact, ovf;
    int                    sh;
    logic [W-1:0]          res;
    logic [3:0]            flg;

    always_comb begin
        if (s2_q.prod[PW-1]) begin
            sig = s2_q.prod;
            be  = $signed(s2_q.exp) + BIAS_X1;
        end else begin
            sig = s2_q.prod << 1;
            be  = $signed(s2_q.exp) + BIAS_X;
        end
        tiny = be[EW-1] || (be == '0);

        // Denormalising shift happens before rounding so G/R/S see the final bit positions.
        sh        = tiny ? 1 - int'(be) : 0;
        shf       = sig >> sh;
        sh_sticky = 1'b0;
        for (int i = 0; i < int'(PW); i++) begin
            if (i < sh) begin
                sh_sticky = sh_sticky | sig[i];
            end
        end

        frac    = shf[PW-2 -: MAN_W];
        guard   = shf[PW-MAN_W-2];
        rnd     = shf[PW-MAN_W-3];
        stk     = (|shf[PW-MAN_W-4:0]) | sh_sticky;
        inexact = guard | rnd | stk;
        e_pre   = shf[PW-1] ? be : '0;
        inc     = (s2_q.rm == RM_RNE) && guard && (rnd || stk || frac[0]);
        // Packed add lets a mantissa carry ripple into the exponent field.
        rounded = {e_pre, frac} + {{(EW+MAN_W-1){1'b0}}, inc};
        be_r    = rounded[EW+MAN_W-1 -: EW];
        ovf     = (be_r >= EXP_MAX);

        res = {s2_q.sign, rounded[EXP_W+MAN_W-1:0]};
        flg = '0;
        if (s2_q.spec) begin
            res          = s2_q.res;
            flg[FLAG_NV] = s2_q.nv;
        end else if (ovf) begin
            if (s2_q.rm == RM_RTZ) begin
                res = {s2_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            end else begin
                res = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            flg[FLAG_OF] = 1'b1;
            flg[FLAG_NX] = 1'b1;
        end else begin
            flg[FLAG_NX] = inexact;
            flg[FLAG_UF] = tiny && inexact;
        end

        out_valid_d = out_valid_q;
        out_d       = out_q;
        flags_d     = flags_q;
        if (advance) begin
            out_valid_d = s2_q.valid;
            if (s2_q.valid) begin
                out_d   = res;
                flags_d = flg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed-vector bench for fmul_pipe: FP32 and FP16 instances, hand-computed products,
// streaming with output back-pressure, and reset while operations are in flight.
module tb_fmul_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid32, in_ready32, rm32, out_valid32, out_ready32;
    logic [31:0] a32, b32, out32;
    logic [3:0]  flags32;

    logic        in_valid16, in_ready16, rm16, out_valid16, out_ready16;
    logic [15:0] a16, b16, out16;
    logic [3:0]  flags16;

    int n_checks;
    int n_fail;

    fmul_pipe #(
        .EXP_W (8),
        .MAN_W (23)
    ) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .a         (a32),
        .b         (b32),
        .rm        (rm32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out       (out32),
        .flags     (flags32)
    );

    fmul_pipe #(
        .EXP_W (5),
        .MAN_W (10)
    ) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .rm        (rm16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out       (out16),
        .flags     (flags16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated transaction on either instance (h=1 selects FP16).
    task automatic run_op(input bit h, input string tag, input logic [31:0] opa,
                          input logic [31:0] opb, input logic r, input logic [31:0] want,
                          input logic [3:0] want_flags);
        int lat;
        @(negedge clk);
        if (h) begin
            in_valid16 = 1'b1;
            a16        = opa[15:0];
            b16        = opb[15:0];
            rm16       = r;
        end else begin
            in_valid32 = 1'b1;
            a32        = opa;
            b32        = opb;
            rm32       = r;
        end
        #1;
        check_eq({tag, ".in_ready"}, h ? in_ready16 : in_ready32, 1'b1);
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        in_valid32 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(h ? out_valid16 : out_valid32) && lat < 10);
        check_eq({tag, ".latency"}, lat, 3);
        check_eq({tag, ".out"}, h ? out16 : out32, want);
        check_eq({tag, ".flags"}, h ? flags16 : flags32, want_flags);
        @(negedge clk);
        check_eq({tag, ".pulse"}, h ? out_valid16 : out_valid32, 1'b0);
    endtask

    logic [31:0] sa [4];
    logic [31:0] sb [4];
    logic [31:0] sexp [4];
    logic [31:0] held_out;
    int          sent, got, seen;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        in_valid32  = 1'b0;
        in_valid16  = 1'b0;
        out_ready32 = 1'b1;
        out_ready16 = 1'b1;
        rm32        = 1'b0;
        rm16        = 1'b0;
        a32         = '0;
        b32         = '0;
        a16         = '0;
        b16         = '0;
        held_out    = '0;

        repeat (2) @(negedge clk);
        check_eq("reset.in_ready32", in_ready32, 1'b0);
        check_eq("reset.in_ready16", in_ready16, 1'b0);
        check_eq("reset.out_valid", out_valid32, 1'b0);
        check_eq("reset.out", out32, 32'h0);
        check_eq("reset.flags", flags32, 4'h0);
        rst_n = 1'b1;

        // Basic and rounding
        run_op(0, "basic", 32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 4'b0000);
        run_op(0, "rne_up", 32'h3FC00001, 32'h3FC00000, 1'b0, 32'h40100001, 4'b0001);
        run_op(0, "rtz_trunc", 32'h3FC00001, 32'h3FC00000, 1'b1, 32'h40100000, 4'b0001);
        run_op(0, "tie_even", 32'h3F800003, 32'h3FC00000, 1'b0, 32'h3FC00004, 4'b0001);
        run_op(0, "tie_odd", 32'h3F800001, 32'h40400000, 1'b0, 32'h40400002, 4'b0001);

        // Specials
        run_op(0, "inf_x_zero", 32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op(0, "zero_x_inf", 32'h00000000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op(0, "qnan", 32'h7FC00000, 32'h40000000, 1'b0, 32'h7FC00000, 4'b0000);
        run_op(0, "snan", 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op(0, "neg_inf", 32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000);
        run_op(0, "neg_zero", 32'h80000000, 32'h40000000, 1'b0, 32'h80000000, 4'b0000);

        // Overflow and subnormals
        run_op(0, "ovf_rne", 32'h7F7FFFFF, 32'h40000000, 1'b0, 32'h7F800000, 4'b0101);
        run_op(0, "ovf_rtz", 32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F7FFFFF, 4'b0101);
        run_op(0, "sub_exact", 32'h00000001, 32'h3F800000, 1'b0, 32'h00000001, 4'b0000);
        run_op(0, "sub_to_zero", 32'h00000001, 32'h3F000000, 1'b0, 32'h00000000, 4'b0011);
        run_op(0, "sub_to_norm", 32'h00400000, 32'h40000000, 1'b0, 32'h00800000, 4'b0000);
        run_op(0, "norm_to_sub", 32'h00800000, 32'h3F000000, 1'b0, 32'h00400000, 4'b0000);

        // FP16 instance
        run_op(1, "h_basic", 32'h4000, 32'h4200, 1'b0, 32'h4600, 4'b0000);
        run_op(1, "h_ovf", 32'h7BFF, 32'h4000, 1'b0, 32'h7C00, 4'b0101);
        run_op(1, "h_sub", 32'h0001, 32'h3C00, 1'b0, 32'h0001, 4'b0000);

        // Back-to-back stream with two stalled output cycles
        sa   = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 32'h40000000};
        sb   = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h40400000};
        sexp = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h40C00000};
        sent = 0;
        got  = 0;
        rm32 = 1'b0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge clk);
            out_ready32 = (c != 4 && c != 5);
            in_valid32  = (sent < 4);
            if (sent < 4) begin
                a32 = sa[sent];
                b32 = sb[sent];
            end
            #1;
            if (c == 5) begin
                check_eq("stall.hold_valid", out_valid32, 1'b1);
                check_eq("stall.hold_out", out32, held_out);
            end
            if (c == 4) held_out = out32;
            if (!out_ready32) check_eq("stall.in_ready", in_ready32, 1'b0);
            if (out_valid32 && out_ready32) begin
                check_eq($sformatf("stream.res%0d", got), out32, sexp[got]);
                got++;
            end
            if (in_valid32 && in_ready32) sent++;
        end
        check_eq("stream.count", got, 4);
        @(negedge clk);
        in_valid32  = 1'b0;
        out_ready32 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset with two operations in flight
        in_valid32 = 1'b1;
        a32        = 32'h40000000;
        b32        = 32'h40400000;
        @(negedge clk);
        a32 = 32'h3F800000;
        b32 = 32'h3F800000;
        @(negedge clk);
        in_valid32 = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_eq("rst.in_ready_low", in_ready32, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst.out_valid", out_valid32, 1'b0);
        check_eq("rst.out", out32, 32'h0);
        check_eq("rst.flags", flags32, 4'h0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid32) seen++;
        end
        check_eq("rst.ghost", seen, 0);
        run_op(0, "rst.after", 32'h40400000, 32'h40400000, 1'b0, 32'h41100000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
